// File: rtl/dft_dump_responder.sv
// DFT dump responder: unloads a core scan chain DUMP_NBR times per request, packing bits into OUT_W-bit strobed words.
// Optional DFT_DUMP_RECIRC_EN: feeds the unloaded bits back into the chain head (non-destructive dump).
module dft_dump_responder #(
    parameter int          CHAIN_LEN = 32,
    parameter int          OUT_W     = 32,
    parameter logic [26:0] DUMP_NBR  = 27'd1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             dft_val_op,
    output logic             dft_op_ack,
    output logic             dft_op_commit,
    input  logic             dft_commit_ack,
    output logic [OUT_W-1:0] dft_output_data,
    output logic             dft_output_strobe,
    output logic             ex_sen,
    input  logic             scan_si,
    output logic             scan_so
);

    localparam int          CNT_W   = $clog2(CHAIN_LEN) + 1;
    localparam int          WB_W    = (OUT_W > 1) ? $clog2(OUT_W) : 1;
    localparam logic [26:0] NBR_EFF = (DUMP_NBR == 27'd0) ? 27'd1 : DUMP_NBR;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ACK,
        S_SHIFT,
        S_CAPTURE,
        S_COMMIT
    } state_t;

    state_t             state_q;
    logic [CNT_W-1:0]   bit_cnt_q;
    logic [WB_W-1:0]    wbit_q;
    logic [26:0]        dump_cnt_q;
    logic [OUT_W-1:0]   word_q;
    logic [OUT_W-1:0]   data_q;
    logic               strobe_q;
    logic               ack_q;
    logic               commit_q;

    logic [OUT_W-1:0]   word_d;
    logic [26:0]        dump_cnt_d;
    logic               last_bit;
    logic               word_done;

    // Word under assembly with the current serial bit merged in, so a completed
    // word can be published in the same edge that samples its last bit.
    always_comb begin
        word_d         = word_q;
        word_d[wbit_q] = scan_si;
    end

    assign last_bit   = (bit_cnt_q == CNT_W'(CHAIN_LEN - 1));
    assign word_done  = (wbit_q == WB_W'(OUT_W - 1));
    assign dump_cnt_d = dump_cnt_q + 27'd1;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= S_IDLE;
            bit_cnt_q  <= '0;
            wbit_q     <= '0;
            dump_cnt_q <= '0;
            word_q     <= '0;
            data_q     <= '0;
            strobe_q   <= 1'b0;
            ack_q      <= 1'b0;
            commit_q   <= 1'b0;
        end else begin
            strobe_q <= 1'b0;
            ack_q    <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (dft_val_op) begin
                        state_q <= S_ACK;
                        ack_q   <= 1'b1;
                    end
                end
                S_ACK: begin
                    bit_cnt_q  <= '0;
                    wbit_q     <= '0;
                    dump_cnt_q <= '0;
                    state_q    <= S_SHIFT;
                end
                S_SHIFT: begin
                    word_q    <= word_d;
                    bit_cnt_q <= bit_cnt_q + CNT_W'(1);
                    wbit_q    <= word_done ? '0 : wbit_q + WB_W'(1);
                    if (word_done) begin
                        data_q   <= word_d;
                        strobe_q <= 1'b1;
                    end
                    if (last_bit) begin
                        dump_cnt_q <= dump_cnt_d;
                        bit_cnt_q  <= '0;
                        if (dump_cnt_d < NBR_EFF) begin
                            state_q <= S_CAPTURE;
                        end else begin
                            state_q  <= S_COMMIT;
                            commit_q <= 1'b1;
                        end
                    end
                end
                S_CAPTURE: begin
                    bit_cnt_q <= '0;
                    wbit_q    <= '0;
                    state_q   <= S_SHIFT;
                end
                S_COMMIT: begin
                    if (dft_commit_ack) begin
                        commit_q <= 1'b0;
                        state_q  <= S_IDLE;
                    end
                end
                default: begin
                    commit_q <= 1'b0;
                    state_q  <= S_IDLE;
                end
            endcase
        end
    end

`ifdef DFT_DUMP_RECIRC_EN
    logic so_q;

    // One-cycle retimed return path keeps scan_si -> scan_so off a combinational path.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            so_q <= 1'b0;
        end else begin
            so_q <= (state_q == S_SHIFT) ? scan_si : 1'b0;
        end
    end

    assign scan_so = so_q;
`else
    assign scan_so = 1'b0;
`endif

    assign ex_sen            = (state_q == S_SHIFT);
    assign dft_op_ack        = ack_q;
    assign dft_op_commit     = commit_q;
    assign dft_output_data   = data_q;
    assign dft_output_strobe = strobe_q;

endmodule

// File: tb/tb_dft_dump_responder.sv
// Bench for dft_dump_responder: instance A (32-bit chain, 1 dump) and instance B (64-bit chain, 2 dumps)
// share stimulus; the unused instance is held in reset.
module tb_dft_dump_responder;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_a, rst_b, sel;
    logic val_op, commit_ack, scan_si;

    logic        a_ack, a_commit, a_strobe, a_sen, a_so;
    logic [31:0] a_data;
    logic        b_ack, b_commit, b_strobe, b_sen, b_so;
    logic [31:0] b_data;

    dft_dump_responder #(.CHAIN_LEN(32), .OUT_W(32), .DUMP_NBR(27'd1)) dut_a (
        .clk(clk), .reset(rst_a), .dft_val_op(val_op), .dft_op_ack(a_ack),
        .dft_op_commit(a_commit), .dft_commit_ack(commit_ack), .dft_output_data(a_data),
        .dft_output_strobe(a_strobe), .ex_sen(a_sen), .scan_si(scan_si), .scan_so(a_so)
    );

    dft_dump_responder #(.CHAIN_LEN(64), .OUT_W(32), .DUMP_NBR(27'd2)) dut_b (
        .clk(clk), .reset(rst_b), .dft_val_op(val_op), .dft_op_ack(b_ack),
        .dft_op_commit(b_commit), .dft_commit_ack(commit_ack), .dft_output_data(b_data),
        .dft_output_strobe(b_strobe), .ex_sen(b_sen), .scan_si(scan_si), .scan_so(b_so)
    );

    logic        o_ack, o_commit, o_strobe, o_sen, o_so;
    logic [31:0] o_data;
    assign o_ack    = sel ? b_ack    : a_ack;
    assign o_commit = sel ? b_commit : a_commit;
    assign o_strobe = sel ? b_strobe : a_strobe;
    assign o_sen    = sel ? b_sen    : a_sen;
    assign o_so     = sel ? b_so     : a_so;
    assign o_data   = sel ? b_data   : a_data;

    int n_tests = 0;
    int n_fail  = 0;

    // Virtual core chain contents (bit 0 leaves first) and what one request produced.
    logic [63:0] pat_g;
    int          obs_t_ack, obs_n_ack, obs_n_sen, obs_first_sen, obs_last_sen;
    int          obs_t_commit, obs_commit_len, obs_strobe_in_commit;
    bit          obs_timeout;
    logic [31:0] obs_words[$];
    logic        obs_so[$];
    logic [31:0] exp_words[$];

    // Reference: each dump reproduces the chain as consecutive OUT_W slices, LSB first.
    task automatic build_expected(input int len, input int ndump);
        exp_words.delete();
        for (int d = 0; d < ndump; d++)
            for (int w = 0; w < len / 32; w++)
                exp_words.push_back(pat_g[w*32 +: 32]);
    endtask

    // Plays the prewrapper and the core chain for one request, recording what the DUT does.
    task automatic run_req(input int len, input int ack_dly, input bit keep_val,
                           input bit poke_val, input bit stray_ack);
        int cyc = 0;
        int bit_i = 0;
        bit prev_sen = 0;
        bit seen_commit = 0;
        bit done = 0;
        obs_t_ack = -1; obs_n_ack = 0; obs_n_sen = 0; obs_first_sen = -1; obs_last_sen = -1;
        obs_t_commit = -1; obs_commit_len = 0; obs_strobe_in_commit = 0; obs_timeout = 0;
        obs_words.delete(); obs_so.delete();
        val_op = 1'b1;
        while (!done && cyc < 400) begin
            @(negedge clk);
            cyc++;
            commit_ack = 1'b0;
            if (o_ack) begin
                obs_n_ack++;
                if (obs_t_ack < 0) obs_t_ack = cyc;
                if (!keep_val) val_op = 1'b0;
            end
            if (prev_sen) obs_so.push_back(o_so);
            if (o_strobe) begin
                obs_words.push_back(o_data);
                if (o_commit) obs_strobe_in_commit++;
            end
            if (o_sen) begin
                obs_n_sen++;
                if (obs_first_sen < 0) obs_first_sen = cyc;
                obs_last_sen = cyc;
                scan_si = pat_g[bit_i % len];
                bit_i++;
                if (poke_val && !keep_val) val_op = (bit_i == 6);
                if (stray_ack) commit_ack = (bit_i == 11);
            end else begin
                scan_si = 1'($urandom);
            end
            if (o_commit) begin
                if (!seen_commit) obs_t_commit = cyc;
                seen_commit = 1;
                obs_commit_len++;
                if (obs_commit_len >= ack_dly) commit_ack = 1'b1;
            end else if (seen_commit) begin
                done = 1;
            end
            prev_sen = o_sen;
        end
        if (!done) obs_timeout = 1;
    endtask

    task automatic test_reset;
        for (int s = 0; s < 2; s++) begin
            sel = 1'(s);
            #1;
            n_tests++;
            if ({o_ack, o_commit, o_strobe, o_sen, o_so, o_data} !== 37'd0) begin
                n_fail++;
                $display("FAIL reset_outputs inst=%0d got ack=%b com=%b stb=%b sen=%b so=%b data=%h, need all 0",
                         s, o_ack, o_commit, o_strobe, o_sen, o_so, o_data);
            end
        end
        sel = 1'b0;
    endtask

    task automatic test_single;
        for (int r = 0; r < 4; r++) begin
            pat_g = (r == 0) ? 64'hA5A51234 : {32'd0, $urandom};
            run_req(32, $urandom_range(1, 4), 0, 0, 0);
            build_expected(32, 1);
            n_tests++;
            if (obs_timeout !== 0) begin n_fail++; $display("FAIL single_timeout r=%0d got 1 need 0", r); end
            n_tests++;
            if (obs_t_ack !== 1) begin n_fail++; $display("FAIL single_ack_latency r=%0d got %0d need 1", r, obs_t_ack); end
            n_tests++;
            if (obs_n_sen !== 32) begin n_fail++; $display("FAIL single_sen_cycles r=%0d got %0d need 32", r, obs_n_sen); end
            n_tests++;
            if (obs_t_commit !== 34) begin n_fail++; $display("FAIL single_commit_time r=%0d got %0d need 34", r, obs_t_commit); end
            n_tests++;
            if (obs_words.size() !== 1 || obs_words[0] !== exp_words[0]) begin
                n_fail++;
                $display("FAIL single_word r=%0d got n=%0d w0=%h need n=1 w0=%h", r, obs_words.size(),
                         (obs_words.size() > 0) ? obs_words[0] : 32'hx, exp_words[0]);
            end
            n_tests++;
            if (obs_strobe_in_commit !== 1) begin n_fail++; $display("FAIL single_strobe_in_commit r=%0d got %0d need 1", r, obs_strobe_in_commit); end
        end
    endtask

    task automatic test_busy_ignored;
        int dly;
        pat_g = {32'd0, $urandom};
        dly = $urandom_range(2, 5);
        run_req(32, dly, 0, 1, 1);
        build_expected(32, 1);
        n_tests++;
        if (obs_n_ack !== 1) begin n_fail++; $display("FAIL busy_ack_count got %0d need 1", obs_n_ack); end
        n_tests++;
        if (obs_t_commit !== 34 || obs_n_sen !== 32) begin
            n_fail++; $display("FAIL busy_timing got commit@%0d sen=%0d need 34/32", obs_t_commit, obs_n_sen);
        end
        n_tests++;
        if (obs_commit_len !== dly) begin n_fail++; $display("FAIL busy_commit_len got %0d need %0d", obs_commit_len, dly); end
        n_tests++;
        if (obs_words.size() !== 1 || obs_words[0] !== exp_words[0]) begin
            n_fail++; $display("FAIL busy_word got n=%0d need 1 word %h", obs_words.size(), exp_words[0]);
        end
    endtask

    task automatic test_idle_stray;
        logic [31:0] held;
        held = exp_words[exp_words.size() - 1];
        @(negedge clk);
        commit_ack = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            commit_ack = 1'b0;
            n_tests++;
            if ({o_ack, o_commit, o_strobe, o_sen} !== 4'b0 || o_data !== held) begin
                n_fail++;
                $display("FAIL idle_stray c=%0d got ack=%b com=%b stb=%b sen=%b data=%h need 0000 data=%h",
                         c, o_ack, o_commit, o_strobe, o_sen, o_data, held);
            end
        end
    endtask

    task automatic test_back_to_back;
        pat_g = {32'd0, $urandom};
        run_req(32, 5, 1, 0, 0);
        build_expected(32, 1);
        n_tests++;
        if (obs_timeout !== 0 || obs_commit_len !== 5) begin
            n_fail++; $display("FAIL b2b_commit_len got %0d (timeout=%0d) need 5", obs_commit_len, obs_timeout);
        end
        n_tests++;
        if (obs_n_ack !== 1 || obs_words.size() !== 1 || obs_words[0] !== exp_words[0]) begin
            n_fail++; $display("FAIL b2b_first got acks=%0d words=%0d need 1/1 %h", obs_n_ack, obs_words.size(), exp_words[0]);
        end
        n_tests++;
        if (o_ack !== 1'b0 || o_commit !== 1'b0) begin
            n_fail++; $display("FAIL b2b_idle_gap got ack=%b commit=%b need 0/0", o_ack, o_commit);
        end
        @(negedge clk);
        n_tests++;
        if (o_ack !== 1'b1) begin n_fail++; $display("FAIL b2b_second_ack got %b need 1", o_ack); end
        val_op = 1'b0;
        rst_a = 1'b0;
        @(negedge clk);
        rst_a = 1'b1;
    endtask

    task automatic test_reset_mid;
        int cnt = 0;
        int k = 0;
        pat_g = {32'd0, $urandom};
        val_op = 1'b1;
        while (cnt < 11 && k < 100) begin
            @(negedge clk);
            k++;
            if (o_ack) val_op = 1'b0;
            if (o_sen) begin scan_si = pat_g[cnt]; cnt++; end
        end
        n_tests++;
        if (cnt !== 11) begin n_fail++; $display("FAIL rmid_reach_bit10 got %0d shifts need 11", cnt); end
        rst_a = 1'b0;
        #1;
        n_tests++;
        if ({o_ack, o_commit, o_strobe, o_sen, o_so, o_data} !== 37'd0) begin
            n_fail++; $display("FAIL rmid_async got sen=%b data=%h need all 0", o_sen, o_data);
        end
        @(negedge clk);
        rst_a = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            n_tests++;
            if ({o_ack, o_commit, o_strobe, o_sen, o_data} !== 36'd0) begin
                n_fail++; $display("FAIL rmid_idle c=%0d got ack=%b sen=%b stb=%b data=%h need 0", c, o_ack, o_sen, o_strobe, o_data);
            end
        end
        pat_g = {32'd0, $urandom};
        run_req(32, 1, 0, 0, 0);
        build_expected(32, 1);
        n_tests++;
        if (obs_timeout !== 0 || obs_words.size() !== 1 || obs_words[0] !== exp_words[0]) begin
            n_fail++; $display("FAIL rmid_fresh_dump got n=%0d need 1 word %h", obs_words.size(), exp_words[0]);
        end
    endtask

    // The core chain receives scan_so one cycle behind each sampled bit; rebuild it and dump again.
    task automatic test_recirc;
        logic [31:0] chain2;
        logic [31:0] want;
`ifdef DFT_DUMP_RECIRC_EN
        want = 32'h13572468;
`else
        want = 32'h00000000;
`endif
        pat_g = 64'h13572468;
        run_req(32, 1, 0, 0, 0);
        n_tests++;
        if (obs_words.size() !== 1 || obs_words[0] !== 32'h13572468) begin
            n_fail++; $display("FAIL recirc_first_dump got n=%0d need 1 word 13572468", obs_words.size());
        end
        chain2 = '0;
        n_tests++;
        if (obs_so.size() !== 32) begin
            n_fail++; $display("FAIL recirc_so_len got %0d need 32", obs_so.size());
        end else begin
            for (int i = 0; i < 32; i++) chain2[i] = obs_so[i];
        end
        pat_g = {32'd0, chain2};
        run_req(32, 1, 0, 0, 0);
        n_tests++;
        if (obs_words.size() !== 1 || obs_words[0] !== want) begin
            n_fail++; $display("FAIL recirc_second_dump got %h need %h", (obs_words.size() > 0) ? obs_words[0] : 32'hx, want);
        end
    endtask

    task automatic test_multi;
        for (int r = 0; r < 3; r++) begin
            pat_g = (r == 0) ? 64'h0000FFFF_DEADBEEF : {$urandom, $urandom};
            run_req(64, $urandom_range(1, 3), 0, 0, 0);
            build_expected(64, 2);
            n_tests++;
            if (obs_timeout !== 0 || obs_t_commit !== 131) begin
                n_fail++; $display("FAIL multi_commit_time r=%0d got %0d need 131", r, obs_t_commit);
            end
            n_tests++;
            if (obs_n_sen !== 128 || (obs_last_sen - obs_first_sen + 1 - obs_n_sen) !== 1) begin
                n_fail++; $display("FAIL multi_capture_gap r=%0d got sen=%0d gap=%0d need 128/1", r, obs_n_sen,
                                   obs_last_sen - obs_first_sen + 1 - obs_n_sen);
            end
            n_tests++;
            if (obs_words.size() !== 4) begin
                n_fail++; $display("FAIL multi_word_count r=%0d got %0d need 4", r, obs_words.size());
            end else begin
                for (int i = 0; i < 4; i++) begin
                    n_tests++;
                    if (obs_words[i] !== exp_words[i]) begin
                        n_fail++; $display("FAIL multi_word r=%0d i=%0d got %h need %h", r, i, obs_words[i], exp_words[i]);
                    end
                end
            end
        end
    endtask

    initial begin
        sel = 1'b0; rst_a = 1'b0; rst_b = 1'b0;
        val_op = 1'b0; commit_ack = 1'b0; scan_si = 1'b0;
        pat_g = '0;
        repeat (2) @(negedge clk);
        test_reset;
        rst_a = 1'b1;
        @(negedge clk);
        test_single;
        test_busy_ignored;
        test_idle_stray;
        test_back_to_back;
        test_reset_mid;
        test_recirc;
        rst_a = 1'b0;
        sel = 1'b1;
        @(negedge clk);
        rst_b = 1'b1;
        @(negedge clk);
        test_multi;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
